// File: rtl/gray_cnt.sv
// ---------------------------------------------------------------------------
// gray_cnt
//  Registered up/down Gray-code counter. An internal binary count is stepped
//  or loaded and its Gray encoding is registered on g, so an enabled step
//  changes exactly one bit of g. g drives a downstream Gray-to-binary stage.
//
//  Parameters
//    WIDTH     counter and Gray code width in bits (>= 2)
//
//  Ports
//    clk       in   rising-edge clock
//    rst       in   asynchronous active-high reset
//    en        in   count enable, one step per cycle while high
//    up        in   direction, 1 = increment, 0 = decrement
//    load      in   parallel load strobe, priority over en
//    load_val  in   Gray-coded load value
//    g         out  registered Gray-coded count
//    g_vld     out  one-cycle pulse, g updated on this edge
//    wrap      out  one-cycle pulse, this update wrapped the count
//
//  Build option
//    GRAY_CNT_SAT_EN  defined: counter saturates at both ends instead of
//                     wrapping; a blocked step produces no g_vld and wrap
//                     stays 0. Port list is the same in both builds.
// ---------------------------------------------------------------------------
module gray_cnt #(
   parameter int unsigned WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             up,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] g,
   output logic             g_vld,
   output logic             wrap
);

   localparam logic [WIDTH-1:0] BIN_MAX  = '1;
   localparam logic [WIDTH-1:0] BIN_ZERO = '0;
   localparam logic [WIDTH-1:0] BIN_ONE  = WIDTH'(1);

   // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
   function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] gv);
      logic [WIDTH-1:0] b;
      b            = '0;
      b[WIDTH-1]   = gv[WIDTH-1];
      for (int i = int'(WIDTH) - 2; i >= 0; i--) begin
         b[i] = b[i+1] ^ gv[i];
      end
      return b;
   endfunction

   // Binary to reflected Gray code.
   function automatic logic [WIDTH-1:0] bin2gray(input logic [WIDTH-1:0] bv);
      return bv ^ (bv >> 1);
   endfunction

   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] g_q,   g_d;
   logic             g_vld_q, g_vld_d;
   logic             wrap_q,  wrap_d;

   logic [WIDTH-1:0] step_bin;
   logic             at_edge;

   // Candidate next count and whether the step crosses the modulo boundary.
   always_comb begin
      step_bin = up ? (cnt_q + BIN_ONE) : (cnt_q - BIN_ONE);
      at_edge  = up ? (cnt_q == BIN_MAX) : (cnt_q == BIN_ZERO);
   end

   // Next-state selection: load > en > hold; strobes default low.
   always_comb begin
      cnt_d   = cnt_q;
      g_d     = g_q;
      g_vld_d = 1'b0;
      wrap_d  = 1'b0;
      if (load) begin
         cnt_d   = gray2bin(load_val);
         g_d     = load_val;
         g_vld_d = 1'b1;
      end else if (en) begin
`ifdef GRAY_CNT_SAT_EN
         // At the end of range the step is dropped entirely.
         if (!at_edge) begin
            cnt_d   = step_bin;
            g_d     = bin2gray(step_bin);
            g_vld_d = 1'b1;
         end
`else
         cnt_d   = step_bin;
         g_d     = bin2gray(step_bin);
         g_vld_d = 1'b1;
         wrap_d  = at_edge;
`endif
      end
   end

   // State and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q   <= '0;
         g_q     <= '0;
         g_vld_q <= 1'b0;
         wrap_q  <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         g_q     <= g_d;
         g_vld_q <= g_vld_d;
         wrap_q  <= wrap_d;
      end
   end

   assign g     = g_q;
   assign g_vld = g_vld_q;
   assign wrap  = wrap_q;

endmodule
